// File: rtl/l1_norm_accum.sv
// rtl/l1_norm_accum.sv - streaming L1-norm accumulator with IDLE/ACCUM/DONE sequencing
// Optional build macro L1_NORM_SIGNED_IN_EN: take |in_data| of signed inputs before accumulating.
module l1_norm_accum #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8,
    parameter int ACC_WIDTH = WIDTH + LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEN_WIDTH-1:0]   count;
    logic                   in_fire;
    logic [WIDTH-1:0]       mag_bits;
    logic                   mag_carry;
    logic [ACC_WIDTH-1:0]   acc_sum;

    localparam logic [LEN_WIDTH-1:0] COUNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    assign in_fire = in_valid & in_ready;

`ifdef L1_NORM_SIGNED_IN_EN
    // Negate as ~x + 1 with the sign bit as carry-in; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    assign mag_bits  = in_data ^ {WIDTH{in_data[WIDTH-1]}};
    assign mag_carry = in_data[WIDTH-1];
`else
    assign mag_bits  = in_data;
    assign mag_carry = 1'b0;
`endif

    assign acc_sum = acc
                   + {{(ACC_WIDTH-WIDTH){1'b0}}, mag_bits}
                   + {{(ACC_WIDTH-1){1'b0}}, mag_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire && count == COUNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        count <= len;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        acc   <= acc_sum;
                        count <= count - COUNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;

endmodule

// File: tb/tb_l1_norm_accum.sv
// tb/tb_l1_norm_accum.sv - scoreboard bench for l1_norm_accum with randomized vectors
module tb_l1_norm_accum;

    localparam int WIDTH     = 8;
    localparam int LEN_WIDTH = 4;
    localparam int ACC_WIDTH = WIDTH + LEN_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_WIDTH-1:0] vlen;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int issued   = 0;
    int received = 0;
    int exp_q[$];
    logic [WIDTH-1:0] elems[16];
    int last_sum;

    l1_norm_accum #(
        .WIDTH(WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(vlen),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference magnitude: plain integer absolute value of the element's numeric meaning.
    function automatic int magnitude(input logic [WIDTH-1:0] d);
        int v;
`ifdef L1_NORM_SIGNED_IN_EN
        v = int'($signed(d));
        if (v < 0) v = -v;
`else
        v = int'(d);
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            received++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("scoreboard_sum", int'(out_sum), exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 back-to-back, 1 bubble between elements, 2 random bubbles
    task automatic run_vector(input int n, input int mode, input int hold);
        int sum;
        int stable;
        sum = 0;
        for (int i = 0; i < n; i++) sum += magnitude(elems[i]);
        sum = sum % (1 << ACC_WIDTH);
        check("idle_before_start", int'(busy), 0);
        exp_q.push_back(sum);
        issued++;
        start = 1'b1;
        vlen  = LEN_WIDTH'(n);
        tick();
        start = 1'b0;
        vlen  = '0;
        if (n == 0) begin
            check("zero_len_in_ready", int'(in_ready), 0);
        end
        for (int i = 0; i < n; i++) begin
            if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                tick();
                check("bubble_busy", int'(busy), 1);
                check("bubble_no_out", int'(out_valid), 0);
            end
            check("in_ready_accum", int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = elems[i];
            tick();
        end
        in_valid = 1'b0;
        check("done_latency", int'(out_valid), 1);
        check("done_in_ready", int'(in_ready), 0);
        stable = int'(out_sum);
        last_sum = stable;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            vlen  = LEN_WIDTH'($urandom);
            tick();
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_sum", int'(out_sum), stable);
        end
        out_ready = 1'b1;
        start = 1'b1;
        vlen  = LEN_WIDTH'(3);
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        vlen  = '0;
        check("idle_after_done", int'(busy), 0);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_signed;
        rst = 1'b1; start = 1'b0; vlen = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sum", int'(out_sum), 0);
        check("reset_busy", int'(busy), 0);

        elems[0] = 8'd5; elems[1] = 8'd10; elems[2] = 8'd255;
`ifndef L1_NORM_SIGNED_IN_EN
        run_vector(3, 0, 0);
        check("basic_sum", last_sum, 270);
`endif

        run_vector(0, 0, 0);
        check("zero_len_sum", last_sum, 0);

        elems[0] = 8'd1; elems[1] = 8'd2;
        run_vector(2, 0, 5);
        check("backpressure_sum", last_sum, 3);

        elems[0] = 8'd1; elems[1] = 8'd2; elems[2] = 8'd3; elems[3] = 8'd4;
        run_vector(4, 1, 0);
        check("bubble_sum", last_sum, 10);

        start = 1'b1; vlen = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'd9; tick();
        in_data = 8'd11; tick();
        in_valid = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_sum", int'(out_sum), 0);
        check("abort_busy", int'(busy), 0);
        elems[0] = 8'd7;
        run_vector(1, 0, 0);
        check("after_abort_sum", last_sum, 7);

        elems[0] = 8'h80; elems[1] = 8'hFF; elems[2] = 8'h05;
`ifdef L1_NORM_SIGNED_IN_EN
        exp_signed = 134;
`else
        exp_signed = 388;
`endif
        run_vector(3, 0, 1);
        check("signed_vector_sum", last_sum, exp_signed);

        elems[0] = 8'hFF;
        for (int i = 1; i < 15; i++) elems[i] = 8'hFF;
        run_vector(15, 0, 0);
        check("max_len_sum", last_sum, 15 * magnitude(8'hFF));

        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) elems[i] = WIDTH'($urandom);
            run_vector(n, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        tick();
        check("outputs_received", received, issued);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_norm_accum.md
# l1_norm_accum

Streaming L1-norm accumulator that sits directly downstream of the n-bit absolute-value stage in the PIM datapath. It accepts one magnitude per cycle over a valid/ready handshake and sums a vector of `len` elements. It then presents the sum on a valid/ready output port. A three-state FSM sequences the block, with an element down-counter and a widened accumulator so no intermediate overflow is possible.

## Interface
- `WIDTH`, 32, bit width of each input element.
- `LEN_WIDTH`, 8, bit width of the vector-length field; maximum vector length is 2^LEN_WIDTH-1.
- `ACC_WIDTH`, `WIDTH+LEN_WIDTH`, accumulator and output width; must be at least `WIDTH+LEN_WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a vector; sampled only in IDLE.
- `len`  in  LEN_WIDTH  element count, captured with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data`; high only in ACCUM.
- `in_data`  in  WIDTH  element; unsigned magnitude (see Configuration).
- `out_valid`  out  1  `out_sum` is valid; high only in DONE.
- `out_ready`  in  1  consumer accepts `out_sum`.
- `out_sum`  out  ACC_WIDTH  L1 norm of the vector.
- `busy`  out  1  high in ACCUM and DONE.

## Operation
- State machine: IDLE, ACCUM, DONE. Reset forces IDLE.
  - In IDLE, `start=1` with `len!=0` clears the accumulator, loads the counter with `len`, and goes to ACCUM.
  - In IDLE, `start=1` with `len==0` clears the accumulator and goes directly to DONE.
  - In ACCUM, each input handshake (`in_valid & in_ready`) adds the zero-extended `in_data` to the accumulator and decrements the counter.
  - The handshake that brings the counter from 1 to 0 moves the block to DONE.
  - In DONE, `out_valid=1` and `out_sum` equals the accumulator. The output handshake (`out_valid & out_ready`) returns the block to IDLE.
- `start` is ignored outside IDLE, including in the DONE cycle where `out_ready=1`. A new vector can start no earlier than the cycle after the block returns to IDLE.
- `in_valid` bubbles stall accumulation. State and counter do not change and no element is lost.
- `out_sum`, `out_valid` and `in_ready` hold stable while `out_ready=0`.
- Arithmetic is unsigned and modulo 2^ACC_WIDTH. With the minimum `ACC_WIDTH` it can never wrap.
- Reset values: `in_ready=0`, `out_valid=0`, `out_sum=0`, `busy=0`, accumulator 0, counter 0.
- `rst` asserted mid-vector or mid-DONE aborts the operation:
  - Partial sum discarded, IDLE entered next edge.
  - `rst` has priority over every other input.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Throughput: one element per cycle while `in_valid=1`.
- Latency: `out_valid` rises on the edge after the final input handshake. The sum includes that element.
- `len==0`: `out_valid` rises on the edge after `start` is sampled.
- Minimum vector turnaround is `len + 2` cycles: start edge, `len` accepts, and one DONE cycle with `out_ready=1`.

## Configuration
- `L1_NORM_SIGNED_IN_EN`
  - Defined: `in_data` is two's-complement signed. The block takes its absolute value internally before accumulating, with negation done as bitwise inversion plus the sign bit used as carry-in. The most negative value -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), interpreted unsigned.
  - Undefined: `in_data` is already an unsigned magnitude and is added as-is.
  - Ports, timing and FSM are identical in both builds.

## Test plan
All scenarios use WIDTH=8, LEN_WIDTH=4.
- Basic sum: `start` with `len=3`, inputs 5, 10, 255 back-to-back, `out_ready=1` -> `out_valid` high exactly one cycle after the third accept; `out_sum=270`; IDLE on the next edge.
- Zero length: `start` with `len=0` -> `in_ready` never rises; `out_valid=1` with `out_sum=0` on the next cycle.
- Backpressure:
  - Stimulus: finish `len=2` with inputs 1, 2; hold `out_ready=0` for 5 cycles while pulsing `start`.
  - Response: `out_sum=3` stays stable and `out_valid` stays high; `start` is ignored; IDLE follows the cycle `out_ready=1`.
- Input bubbles: `len=4`, inputs 1, 2, 3, 4 with `in_valid` low on alternate cycles -> `out_sum=10`; only 4 handshakes counted; `busy` high throughout.
- Reset mid-vector:
  - Stimulus: `len=4`, accept 2 elements, pulse `rst` for 1 cycle.
  - Response: all outputs 0 and state IDLE next cycle.
  - Follow-up: `start` with `len=1` and input 7 gives `out_sum=7`, with no residue from the aborted vector.
- Signed build (`L1_NORM_SIGNED_IN_EN` defined): `len=3`, inputs 0x80, 0xFF, 0x05 -> `out_sum=134` (128+1+5). Without the macro, the same inputs give `out_sum=388`.
